// File: rtl/waveform_to_pipe_fifo_if.sv
// Handshake bundle between the fabric-side sample source / host pipe endpoint and
// the waveform capture FIFO. The slave modport is the FIFO's view.
interface waveform_to_pipe_fifo_if #(
    parameter int ADDR_W = 10
);
    logic              sample_en;
    logic [31:0]       sample_data;
    logic              pipe_read;
    logic [15:0]       pipe_data;
    logic              pipe_ready;
    logic [ADDR_W:0]   fill_level;
    logic [15:0]       overflow_cnt;
    logic              underflow;

    modport master (
        output sample_en, sample_data, pipe_read,
        input  pipe_data, pipe_ready, fill_level, overflow_cnt, underflow
    );

    modport slave (
        input  sample_en, sample_data, pipe_read,
        output pipe_data, pipe_ready, fill_level, overflow_cnt, underflow
    );
endinterface

// File: rtl/waveform_to_pipe_fifo.sv
// Captures 32-bit samples as 16-bit words (low half first) into a BRAM FIFO served to a
// block-throttled pipe-out endpoint. Define WAVE_PIPE_TIMESTAMP_EN to prefix each sample with an index word.
module waveform_to_pipe_fifo #(
    parameter int ADDR_W      = 10,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,
    waveform_to_pipe_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
`ifdef WAVE_PIPE_TIMESTAMP_EN
    localparam int WPS = 3;
`else
    localparam int WPS = 2;
`endif
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] WPS_L   = (ADDR_W+1)'(WPS);
    localparam logic [ADDR_W:0] BLOCK_L = (ADDR_W+1)'(BLOCK_WORDS);

`ifdef WAVE_PIPE_TIMESTAMP_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2,
        ST_WR_TS = 2'd3
    } state_t;
    localparam state_t ST_FIRST = ST_WR_TS;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2
    } state_t;
    localparam state_t ST_FIRST = ST_WR_LO;
`endif

    logic [15:0]     r_mem [DEPTH];
    state_t          r_state;
    logic [31:0]     r_hold;
    logic [15:0]     r_overflow_cnt;
    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic [ADDR_W:0] r_fill_level;
    logic            r_pipe_ready;
    logic [15:0]     r_pipe_data;
    logic            r_underflow;
`ifdef WAVE_PIPE_TIMESTAMP_EN
    logic [15:0]     r_index;
`endif

    logic            w_empty;
    logic            w_full;
    logic [ADDR_W:0] w_free;
    logic            w_admit;
    logic            w_drop;
    logic            w_pop;
    logic            w_wr_state;
    logic            w_wr_en;
    logic [15:0]     w_wr_data;
    logic [ADDR_W:0] w_wr_ptr_nxt;
    logic [ADDR_W:0] w_rd_ptr_nxt;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    // Admission uses the pre-read fill level, so a same-cycle pop never lets a sample in early.
    assign w_free  = DEPTH_L - r_fill_level;
    assign w_admit = (w_free >= WPS_L);
    assign w_drop  = bus.sample_en && ((r_state != ST_IDLE) || !w_admit);
    assign w_pop   = bus.pipe_read && !w_empty;
    assign w_wr_en = w_wr_state && !w_full;

    assign w_wr_ptr_nxt = r_wr_ptr + (ADDR_W+1)'(w_wr_en);
    assign w_rd_ptr_nxt = r_rd_ptr + (ADDR_W+1)'(w_pop);

    // Select the word the current write state stores.
    always_comb begin
        w_wr_state = 1'b0;
        w_wr_data  = 16'h0000;
        case (r_state)
            ST_WR_LO: begin
                w_wr_state = 1'b1;
                w_wr_data  = r_hold[15:0];
            end
            ST_WR_HI: begin
                w_wr_state = 1'b1;
                w_wr_data  = r_hold[31:16];
            end
`ifdef WAVE_PIPE_TIMESTAMP_EN
            ST_WR_TS: begin
                w_wr_state = 1'b1;
                w_wr_data  = r_index;
            end
`endif
            default: begin
                w_wr_state = 1'b0;
                w_wr_data  = 16'h0000;
            end
        endcase
    end

    // Write FSM: admit whole samples atomically, count every dropped strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_hold         <= 32'h0000_0000;
            r_overflow_cnt <= 16'h0000;
`ifdef WAVE_PIPE_TIMESTAMP_EN
            r_index        <= 16'h0000;
`endif
        end else begin
            if (w_drop && (r_overflow_cnt != 16'hFFFF)) begin
                r_overflow_cnt <= r_overflow_cnt + 16'h0001;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.sample_en && w_admit) begin
                        r_hold  <= bus.sample_data;
                        r_state <= ST_FIRST;
                    end
                end
`ifdef WAVE_PIPE_TIMESTAMP_EN
                ST_WR_TS: begin
                    r_index <= r_index + 16'h0001;
                    r_state <= ST_WR_LO;
                end
`endif
                ST_WR_LO: r_state <= ST_WR_HI;
                ST_WR_HI: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Word storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_wr_data;
        end
    end

    // Pointers, occupancy, block-ready flag and registered read port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fill_level <= '0;
            r_pipe_ready <= 1'b0;
            r_pipe_data  <= 16'h0000;
            r_underflow  <= 1'b0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_fill_level <= w_wr_ptr_nxt - w_rd_ptr_nxt;
            r_pipe_ready <= (r_fill_level >= BLOCK_L);
            if (w_pop) begin
                r_pipe_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
            end
            if (bus.pipe_read && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.pipe_data    = r_pipe_data;
    assign bus.pipe_ready   = r_pipe_ready;
    assign bus.fill_level   = r_fill_level;
    assign bus.overflow_cnt = r_overflow_cnt;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_waveform_to_pipe_fifo.sv
// Directed bench for waveform_to_pipe_fifo: a queue-based model of the capture FIFO is
// checked against the DUT after every clock, plus literal expectations for key scenarios.
module tb_waveform_to_pipe_fifo;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BLOCK  = 256;
`ifdef WAVE_PIPE_TIMESTAMP_EN
    localparam int WPS = 3;
`else
    localparam int WPS = 2;
`endif

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    waveform_to_pipe_fifo_if #(.ADDR_W(ADDR_W)) bus ();

    waveform_to_pipe_fifo #(.ADDR_W(ADDR_W), .BLOCK_WORDS(BLOCK)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: stored words, words still to be written, visible outputs.
    logic [15:0] fifo_q[$];
    logic [15:0] pend_q[$];
    logic [15:0] m_data;
    logic [15:0] m_ovf;
    logic        m_under;
    logic        m_ready;
    logic [15:0] m_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        fifo_q.delete();
        pend_q.delete();
        m_data  = 16'h0000;
        m_ovf   = 16'h0000;
        m_under = 1'b0;
        m_ready = 1'b0;
        m_idx   = 16'h0000;
    endtask

    task automatic model_step(input logic en, input logic [31:0] d, input logic rd);
        int pre;
        bit busy;
        pre  = fifo_q.size();
        busy = (pend_q.size() != 0);
        if (rd) begin
            if (pre == 0) m_under = 1'b1;
            else          m_data  = fifo_q.pop_front();
        end
        if (busy) fifo_q.push_back(pend_q.pop_front());
        m_ready = (pre >= BLOCK);
        if (en) begin
            if (busy || ((DEPTH - pre) < WPS)) begin
                if (m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'h0001;
            end else begin
`ifdef WAVE_PIPE_TIMESTAMP_EN
                pend_q.push_back(m_idx);
                m_idx = m_idx + 16'h0001;
`endif
                pend_q.push_back(d[15:0]);
                pend_q.push_back(d[31:16]);
            end
        end
    endtask

    task automatic compare();
        chk("pipe_data",    32'(bus.pipe_data),    32'(m_data));
        chk("fill_level",   32'(bus.fill_level),   32'(fifo_q.size()));
        chk("pipe_ready",   32'(bus.pipe_ready),   32'(m_ready));
        chk("overflow_cnt", 32'(bus.overflow_cnt), 32'(m_ovf));
        chk("underflow",    32'(bus.underflow),    32'(m_under));
    endtask

    task automatic tick(input logic en, input logic [31:0] d, input logic rd);
        bus.sample_en   = en;
        bus.sample_data = d;
        bus.pipe_read   = rd;
        @(posedge clk);
        model_step(en, d, rd);
        #1;
        compare();
        bus.sample_en = 1'b0;
        bus.pipe_read = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        bus.sample_en   = 1'b0;
        bus.sample_data = 32'h0;
        bus.pipe_read   = 1'b0;
        reset_n = 1'b0;
        #1;
        model_clear();
        compare();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] pat(input int i);
        return {16'hA000 + 16'(i), 16'h5000 + 16'(i)};
    endfunction

    task automatic fill_to_limit(output int n);
        n = 0;
        while ((DEPTH - fifo_q.size()) >= WPS) begin
            tick(1'b1, pat(n), 1'b0);
            idle(WPS);
            n++;
        end
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while ((fifo_q.size() != 0 || pend_q.size() != 0) && k < limit) begin
            tick(1'b0, 32'h0, 1'b1);
            k++;
        end
        chk("drain_bound", 32'(fifo_q.size()), 32'd0);
    endtask

    logic [15:0] exp_w[6];
    logic [15:0] last_w[3];
    int n_s;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        do_reset();

        // Basic order
`ifdef WAVE_PIPE_TIMESTAMP_EN
        exp_w = '{16'h0000, 16'h0000, 16'h3F80, 16'h0001, 16'h0000, 16'h42A0};
`else
        exp_w = '{16'h0000, 16'h3F80, 16'h0000, 16'h42A0, 16'h0000, 16'h0000};
`endif
        tick(1'b1, 32'h3F80_0000, 1'b0);
        idle(5);
        chk("basic_fill1", 32'(bus.fill_level), 32'(WPS));
        tick(1'b1, 32'h42A0_0000, 1'b0);
        idle(5);
        chk("basic_fill2", 32'(bus.fill_level), 32'(2 * WPS));
        for (int i = 0; i < 2 * WPS; i++) begin
            tick(1'b0, 32'h0, 1'b1);
            chk("basic_word", 32'(bus.pipe_data), 32'(exp_w[i]));
        end
        chk("basic_fill0", 32'(bus.fill_level), 32'd0);
        chk("basic_under", 32'(bus.underflow), 32'd0);

`ifndef WAVE_PIPE_TIMESTAMP_EN
        // Block ready at 256 words
        do_reset();
        for (int i = 0; i < 127; i++) begin
            tick(1'b1, pat(i), 1'b0);
            idle(2);
        end
        idle(3);
        chk("blk_127_ready", 32'(bus.pipe_ready), 32'd0);
        tick(1'b1, pat(127), 1'b0);
        idle(2);
        chk("blk_fill256", 32'(bus.fill_level), 32'd256);
        idle(1);
        chk("blk_128_ready", 32'(bus.pipe_ready), 32'd1);
        tick(1'b0, 32'h0, 1'b1);
        idle(1);
        chk("blk_read_ready", 32'(bus.pipe_ready), 32'd0);
`endif

        // Overflow: fill to capacity then strobe 3 more
        do_reset();
        fill_to_limit(n_s);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 32'hDEAD_BEEF, 1'b0);
            idle(WPS);
        end
        chk("ovf_cnt", 32'(bus.overflow_cnt), 32'd3);
`ifndef WAVE_PIPE_TIMESTAMP_EN
        chk("ovf_fill", 32'(bus.fill_level), 32'd1024);
`endif
        drain(DEPTH + 8);

        // Busy strobe, then back-to-back reads overlapping WR_HI
        do_reset();
        tick(1'b1, 32'h1234_5678, 1'b0);
        tick(1'b1, 32'h9ABC_DEF0, 1'b0);
        chk("busy_ovf", 32'(bus.overflow_cnt), 32'd1);
`ifdef WAVE_PIPE_TIMESTAMP_EN
        tick(1'b0, 32'h0, 1'b1);
        chk("busy_w0", 32'(bus.pipe_data), 32'h0000);
`endif
        tick(1'b0, 32'h0, 1'b1);
        chk("busy_lo", 32'(bus.pipe_data), 32'h5678);
        tick(1'b0, 32'h0, 1'b1);
        chk("busy_hi", 32'(bus.pipe_data), 32'h1234);

        // Steady state with pointer wrap
        do_reset();
        for (int i = 0; i < 4500; i++) begin
            tick(($urandom_range(0, 2) == 0), $urandom, (fifo_q.size() != 0) && ($urandom_range(0, 3) != 0));
        end
        drain(DEPTH + 8);
        chk("wrap_under0", 32'(bus.underflow), 32'd0);
        tick(1'b0, 32'h0, 1'b1);
        chk("wrap_under1", 32'(bus.underflow), 32'd1);

        // Async reset in the middle of a sample write
        tick(1'b1, 32'hCAFE_F00D, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("arst_fill",  32'(bus.fill_level),   32'd0);
        chk("arst_data",  32'(bus.pipe_data),    32'd0);
        chk("arst_under", 32'(bus.underflow),    32'd0);
        chk("arst_ovf",   32'(bus.overflow_cnt), 32'd0);
        chk("arst_ready", 32'(bus.pipe_ready),   32'd0);
        do_reset();
        idle(4);
        chk("arst_fill_after", 32'(bus.fill_level), 32'd0);

`ifdef WAVE_PIPE_TIMESTAMP_EN
        // Index counts accepted samples only
        do_reset();
        fill_to_limit(n_s);
        tick(1'b0, 32'h0, 1'b1);
        tick(1'b1, 32'h1111_2222, 1'b0);
        idle(WPS);
        chk("ts_drop", 32'(bus.overflow_cnt), 32'd1);
        tick(1'b0, 32'h0, 1'b1);
        tick(1'b1, 32'h3333_4444, 1'b0);
        idle(WPS);
        while (fifo_q.size() != 0) begin
            tick(1'b0, 32'h0, 1'b1);
            last_w[0] = last_w[1];
            last_w[1] = last_w[2];
            last_w[2] = bus.pipe_data;
        end
        chk("ts_idx", 32'(last_w[0]), 32'h0155);
        chk("ts_lo",  32'(last_w[1]), 32'h4444);
        chk("ts_hi",  32'(last_w[2]), 32'h3333);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
